// File: rtl/lc3_mem_access_seq_if.sv
// Memory bus between the LC-3 access sequencer (master) and the memory (slave).
// An access completes in the cycle where mem_req && mem_ready; the master holds every mem_* signal stable while it waits.
interface lc3_mem_access_seq_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/lc3_mem_access_seq.sv
// LC-3 memory-access sequencer: fetch, decode, then 0-2 operand bus cycles per instruction, with a bus-wait timeout.
// Optional macro LC3_ACCESS_STATS_EN adds o_total_acc, a free-running count of completed bus accesses.
module lc3_mem_access_seq #(
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [15:0] i_pc,
    input  logic [15:0] i_base_val,
    input  logic [15:0] i_src_val,
    input  logic [15:0] i_r6_val,
    output logic        o_busy,
    output logic [15:0] o_ir,
    output logic        o_ir_valid,
    output logic [15:0] o_ld_data,
    output logic        o_done,
    output logic [1:0]  o_acc_cnt,
    output logic        o_err,
`ifdef LC3_ACCESS_STATS_EN
    output logic [31:0] o_total_acc,
`endif
    output logic [2:0]  o_dbg_state,
    lc3_mem_access_seq_if.master m_bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_IND_RD  = 3'd3,
        S_DATA_RD = 3'd4,
        S_DATA_WR = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [3:0] OP_LD   = 4'd2;
    localparam logic [3:0] OP_ST   = 4'd3;
    localparam logic [3:0] OP_LDR  = 4'd6;
    localparam logic [3:0] OP_STR  = 4'd7;
    localparam logic [3:0] OP_RTI  = 4'd8;
    localparam logic [3:0] OP_LDI  = 4'd10;
    localparam logic [3:0] OP_STI  = 4'd11;
    localparam logic [3:0] OP_TRAP = 4'd15;
    localparam logic [7:0] LP_WAIT_LAST = 8'(WAIT_TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_pc, w_pc_nxt;
    logic [15:0] r_ir, w_ir_nxt;
    logic [15:0] r_ld_data, w_ld_data_nxt;
    logic [15:0] r_src, w_src_nxt;
    logic [1:0]  r_acc, w_acc_nxt;
    logic [7:0]  r_wait, w_wait_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_ir_valid, w_ir_valid_nxt;
    logic        r_done, w_done_nxt;
    logic [1:0]  r_acc_cnt, w_acc_cnt_nxt;
    logic        r_err, w_err_nxt;
    logic        r_req, w_req_nxt;
    logic        r_we, w_we_nxt;
    logic [15:0] r_addr, w_addr_nxt;
    logic [15:0] r_wdata, w_wdata_nxt;

    logic [3:0]  w_opcode;
    logic [15:0] w_pcoff;
    logic [15:0] w_boff;
    logic        w_complete;
    logic        w_timeout;

    assign w_opcode   = r_ir[15:12];
    assign w_pcoff    = r_pc + 16'd1 + {{7{r_ir[8]}}, r_ir[8:0]};
    assign w_boff     = i_base_val + {{10{r_ir[5]}}, r_ir[5:0]};
    assign w_complete = r_req & m_bus.mem_ready;
    assign w_timeout  = r_req & ~m_bus.mem_ready & (r_wait == LP_WAIT_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_ir_nxt       = r_ir;
        w_ld_data_nxt  = r_ld_data;
        w_src_nxt      = r_src;
        w_acc_nxt      = r_acc;
        w_wait_nxt     = r_wait;
        w_ir_valid_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        w_acc_cnt_nxt  = 2'd0;
        w_err_nxt      = 1'b0;
        w_req_nxt      = r_req;
        w_we_nxt       = r_we;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_pc_nxt    = i_pc;
                    w_addr_nxt  = i_pc;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = 1'b0;
                    w_wait_nxt  = 8'd0;
                    w_acc_nxt   = 2'd0;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH, S_IND_RD, S_DATA_RD, S_DATA_WR: begin
                if (w_complete) begin
                    w_acc_nxt  = r_acc + 2'd1;
                    w_wait_nxt = 8'd0;
                    case (r_state)
                        S_FETCH: begin
                            w_ir_nxt       = m_bus.mem_rdata;
                            w_req_nxt      = 1'b0;
                            w_ir_valid_nxt = 1'b1;
                            w_state_nxt    = S_DECODE;
                        end
                        // Pointer read: the next access starts back-to-back at the pointer.
                        S_IND_RD: begin
                            w_addr_nxt = m_bus.mem_rdata;
                            if (w_opcode == OP_STI) begin
                                w_we_nxt    = 1'b1;
                                w_wdata_nxt = r_src;
                                w_state_nxt = S_DATA_WR;
                            end else begin
                                w_state_nxt = S_DATA_RD;
                            end
                        end
                        default: begin
                            if (r_state == S_DATA_RD) begin
                                w_ld_data_nxt = m_bus.mem_rdata;
                            end
                            w_req_nxt     = 1'b0;
                            w_we_nxt      = 1'b0;
                            w_done_nxt    = 1'b1;
                            w_acc_cnt_nxt = r_acc + 2'd1;
                            w_state_nxt   = S_DONE;
                        end
                    endcase
                end else if (w_timeout) begin
                    w_req_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end
            S_DECODE: begin
                w_src_nxt  = i_src_val;
                w_wait_nxt = 8'd0;
                w_req_nxt  = 1'b1;
                w_we_nxt   = 1'b0;
                case (w_opcode)
                    OP_LD:   begin w_addr_nxt = w_pcoff;               w_state_nxt = S_DATA_RD; end
                    OP_TRAP: begin w_addr_nxt = {8'h00, r_ir[7:0]};    w_state_nxt = S_DATA_RD; end
                    OP_RTI:  begin w_addr_nxt = i_r6_val;              w_state_nxt = S_DATA_RD; end
                    OP_LDR:  begin w_addr_nxt = w_boff;                w_state_nxt = S_DATA_RD; end
                    OP_LDI, OP_STI: begin w_addr_nxt = w_pcoff;        w_state_nxt = S_IND_RD;  end
                    OP_ST, OP_STR: begin
                        w_addr_nxt  = (w_opcode == OP_ST) ? w_pcoff : w_boff;
                        w_we_nxt    = 1'b1;
                        w_wdata_nxt = i_src_val;
                        w_state_nxt = S_DATA_WR;
                    end
                    default: begin
                        w_req_nxt     = 1'b0;
                        w_done_nxt    = 1'b1;
                        w_acc_cnt_nxt = r_acc;
                        w_state_nxt   = S_DONE;
                    end
                endcase
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_we_nxt    = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= 16'd0;
            r_ir       <= 16'd0;
            r_ld_data  <= 16'd0;
            r_src      <= 16'd0;
            r_acc      <= 2'd0;
            r_wait     <= 8'd0;
            r_busy     <= 1'b0;
            r_ir_valid <= 1'b0;
            r_done     <= 1'b0;
            r_acc_cnt  <= 2'd0;
            r_err      <= 1'b0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 16'd0;
            r_wdata    <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ir       <= w_ir_nxt;
            r_ld_data  <= w_ld_data_nxt;
            r_src      <= w_src_nxt;
            r_acc      <= w_acc_nxt;
            r_wait     <= w_wait_nxt;
            r_busy     <= w_busy_nxt;
            r_ir_valid <= w_ir_valid_nxt;
            r_done     <= w_done_nxt;
            r_acc_cnt  <= w_acc_cnt_nxt;
            r_err      <= w_err_nxt;
            r_req      <= w_req_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
        end
    end

`ifdef LC3_ACCESS_STATS_EN
    logic [31:0] r_total_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_total_acc <= 32'd0;
        end else if (w_complete) begin
            r_total_acc <= r_total_acc + 32'd1;
        end
    end

    assign o_total_acc = r_total_acc;
`endif

    assign o_busy          = r_busy;
    assign o_ir            = r_ir;
    assign o_ir_valid      = r_ir_valid;
    assign o_ld_data       = r_ld_data;
    assign o_done          = r_done;
    assign o_acc_cnt       = r_acc_cnt;
    assign o_err           = r_err;
    assign o_dbg_state     = r_state;
    assign m_bus.mem_req   = r_req;
    assign m_bus.mem_we    = r_we;
    assign m_bus.mem_addr  = r_addr;
    assign m_bus.mem_wdata = r_wdata;

endmodule

// File: tb/tb_lc3_mem_access_seq.sv
// Directed bench for lc3_mem_access_seq: a 64K-word memory model with programmable stalls, a bus-access scoreboard and cycle-timing checks.
module tb_lc3_mem_access_seq;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic [15:0] i_pc;
    logic [15:0] i_base_val;
    logic [15:0] i_src_val;
    logic [15:0] i_r6_val;
    logic        o_busy;
    logic [15:0] o_ir;
    logic        o_ir_valid;
    logic [15:0] o_ld_data;
    logic        o_done;
    logic [1:0]  o_acc_cnt;
    logic        o_err;
    logic [2:0]  o_dbg_state;
`ifdef LC3_ACCESS_STATS_EN
    logic [31:0] o_total_acc;
`endif

    lc3_mem_access_seq_if bus ();

    lc3_mem_access_seq #(.WAIT_TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (i_start),
        .i_pc        (i_pc),
        .i_base_val  (i_base_val),
        .i_src_val   (i_src_val),
        .i_r6_val    (i_r6_val),
        .o_busy      (o_busy),
        .o_ir        (o_ir),
        .o_ir_valid  (o_ir_valid),
        .o_ld_data   (o_ld_data),
        .o_done      (o_done),
        .o_acc_cnt   (o_acc_cnt),
        .o_err       (o_err),
`ifdef LC3_ACCESS_STATS_EN
        .o_total_acc (o_total_acc),
`endif
        .o_dbg_state (o_dbg_state),
        .m_bus       (bus.master)
    );

    // Clock and memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    int          stall_cfg;
    int          wait_cnt;

    assign bus.mem_rdata = mem[bus.mem_addr];
    assign bus.mem_ready = (wait_cnt >= stall_cfg);

    always @(posedge clk) begin
        if (bus.mem_req && !bus.mem_ready) wait_cnt <= wait_cnt + 1;
        else                               wait_cnt <= 0;
    end

    // Scoreboard: each entry is {we, addr, wdata}, wdata zero for reads
    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    int n_tests;
    int n_fail;
    int ir_valid_cyc, done_cyc, err_cyc, end_cyc, req_after;
    logic [1:0] done_acc;
    logic       busy_end;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_seq(input logic [15:0] pc_in, input int extra_cyc);
        obs_q.delete();
        ir_valid_cyc = -1; done_cyc = -1; err_cyc = -1; end_cyc = -1;
        req_after = 0; done_acc = 2'd0; busy_end = 1'b0;
        i_pc    = pc_in;
        i_start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 14; c++) begin
            if (bus.mem_req && bus.mem_ready) begin
                obs_q.push_back({bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 16'h0000});
                if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
            end
            if (o_ir_valid && ir_valid_cyc < 0) ir_valid_cyc = c;
            if ((o_done || o_err) && end_cyc < 0) begin
                end_cyc  = c;
                busy_end = o_busy;
                if (o_done) begin done_cyc = c; done_acc = o_acc_cnt; end
                if (o_err)  err_cyc = c;
            end
            if (end_cyc > 0 && bus.mem_req) req_after++;
            i_start = (c == extra_cyc);
            if (i_start) i_pc = 16'hDEAD;
            @(negedge clk);
        end
        i_start = 1'b0;
    endtask

    task automatic check_run(input string name, input int exp_irv, input int exp_done, input int exp_acc);
        check({name, ".ir_valid_cyc"}, 64'(ir_valid_cyc), 64'(exp_irv));
        check({name, ".done_cyc"},     64'(done_cyc),     64'(exp_done));
        check({name, ".acc_cnt"},      64'(done_acc),     64'(exp_acc));
        check({name, ".err_cyc"},      64'(err_cyc),      -64'sd1);
        check({name, ".busy_at_done"}, 64'(busy_end),     64'd1);
        check({name, ".req_after"},    64'(req_after),    64'd0);
    endtask

    task automatic check_accesses(input string name);
        check({name, ".n_acc"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++)
            check($sformatf("%s.acc%0d", name, i), 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
        exp_q.delete();
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        reset = 1'b1; i_start = 1'b0; i_pc = 16'h0;
        i_base_val = 16'h0; i_src_val = 16'h0; i_r6_val = 16'h0;
        stall_cfg = 0; n_tests = 0; n_fail = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst.busy",    64'(o_busy),      64'd0);
        check("rst.mem_req", 64'(bus.mem_req), 64'd0);
        check("rst.done",    64'(o_done),      64'd0);
        check("rst.err",     64'(o_err),       64'd0);
        check("rst.ir",      64'(o_ir),        64'd0);
        check("rst.state",   64'(o_dbg_state), 64'd0);

        // ADD, plus a start during DONE that must be ignored
        mem[16'h3000] = 16'h1261;
        exp_q.push_back({1'b0, 16'h3000, 16'h0000});
        run_seq(16'h3000, 3);
        check_run("add", 2, 3, 1);
        check_accesses("add");
        check("add.ir", 64'(o_ir), 64'h1261);

        // LD positive offset
        mem[16'h3000] = 16'h2205; mem[16'h3006] = 16'hA5A5;
        exp_q.push_back({1'b0, 16'h3000, 16'h0000});
        exp_q.push_back({1'b0, 16'h3006, 16'h0000});
        run_seq(16'h3000, 0);
        check_run("ld", 2, 4, 2);
        check_accesses("ld");
        check("ld.ld_data", 64'(o_ld_data), 64'hA5A5);

        // LD offset -1 reads its own word
        mem[16'h3000] = 16'h21FF;
        exp_q.push_back({1'b0, 16'h3000, 16'h0000});
        exp_q.push_back({1'b0, 16'h3000, 16'h0000});
        run_seq(16'h3000, 0);
        check_run("ldneg", 2, 4, 2);
        check_accesses("ldneg");
        check("ldneg.ld_data", 64'(o_ld_data), 64'h21FF);

        // STI through pointer
        mem[16'h3010] = 16'hB3FE; mem[16'h300F] = 16'h4000; i_src_val = 16'hBEEF;
        exp_q.push_back({1'b0, 16'h3010, 16'h0000});
        exp_q.push_back({1'b0, 16'h300F, 16'h0000});
        exp_q.push_back({1'b1, 16'h4000, 16'hBEEF});
        run_seq(16'h3010, 0);
        check_run("sti", 2, 5, 3);
        check_accesses("sti");
        check("sti.mem", 64'(mem[16'h4000]), 64'hBEEF);

        // STR wrapping to 0x0000
        mem[16'h3020] = 16'h7F81; i_base_val = 16'hFFFF; i_src_val = 16'h1234;
        exp_q.push_back({1'b0, 16'h3020, 16'h0000});
        exp_q.push_back({1'b1, 16'h0000, 16'h1234});
        run_seq(16'h3020, 0);
        check_run("str", 2, 4, 2);
        check_accesses("str");
        check("str.mem", 64'(mem[16'h0000]), 64'h1234);

        // TRAP vector read
        mem[16'h3030] = 16'hF025; mem[16'h0025] = 16'h0400;
        exp_q.push_back({1'b0, 16'h3030, 16'h0000});
        exp_q.push_back({1'b0, 16'h0025, 16'h0000});
        run_seq(16'h3030, 0);
        check_run("trap", 2, 4, 2);
        check_accesses("trap");
        check("trap.ld_data", 64'(o_ld_data), 64'h0400);

        // LDI with a start pulse during DECODE that must be ignored
        mem[16'h3040] = 16'hA002; mem[16'h3043] = 16'h5000; mem[16'h5000] = 16'h7777;
        exp_q.push_back({1'b0, 16'h3040, 16'h0000});
        exp_q.push_back({1'b0, 16'h3043, 16'h0000});
        exp_q.push_back({1'b0, 16'h5000, 16'h0000});
        run_seq(16'h3040, 2);
        check_run("ldi", 2, 5, 3);
        check_accesses("ldi");
        check("ldi.ld_data", 64'(o_ld_data), 64'h7777);

        // RTI pops from R6
        mem[16'h3050] = 16'h8000; mem[16'h2FFE] = 16'h3100; i_r6_val = 16'h2FFE;
        exp_q.push_back({1'b0, 16'h3050, 16'h0000});
        exp_q.push_back({1'b0, 16'h2FFE, 16'h0000});
        run_seq(16'h3050, 0);
        check_run("rti", 2, 4, 2);
        check_accesses("rti");
        check("rti.ld_data", 64'(o_ld_data), 64'h3100);

        // Fetch never answered: timeout after 4 stalled cycles
        stall_cfg = 1000;
        mem[16'h3000] = 16'h1261;
        run_seq(16'h3000, 0);
        check("tmo.err_cyc",   64'(err_cyc),     64'd5);
        check("tmo.done_cyc",  64'(done_cyc),    -64'sd1);
        check("tmo.busy",      64'(busy_end),    64'd0);
        check("tmo.req_after", 64'(req_after),   64'd0);
        check("tmo.n_acc",     64'(obs_q.size()), 64'd0);

        // Three wait cycles complete normally
        stall_cfg = 3;
        exp_q.push_back({1'b0, 16'h3000, 16'h0000});
        run_seq(16'h3000, 0);
        check_run("wait3", 5, 6, 1);
        check_accesses("wait3");

        // Recovery at full speed
        stall_cfg = 0;
        exp_q.push_back({1'b0, 16'h3000, 16'h0000});
        run_seq(16'h3000, 0);
        check_run("after_tmo", 2, 3, 1);
        check_accesses("after_tmo");

        // Asynchronous reset while in IND_RD
        i_pc = 16'h3040; i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ind.state_before", 64'(o_dbg_state), 64'd3);
        reset = 1'b1;
        #1;
        check("rst_ind.busy",    64'(o_busy),      64'd0);
        check("rst_ind.mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_ind.state",   64'(o_dbg_state), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        done_cyc = 0;
        for (int c = 0; c < 6; c++) begin
            if (o_done || o_err || bus.mem_req) done_cyc++;
            @(negedge clk);
        end
        check("rst_ind.quiet", 64'(done_cyc), 64'd0);

        // ADD + LD + LDI after reset: 1 + 2 + 3 accesses
        mem[16'h3000] = 16'h1261;
        run_seq(16'h3000, 0);
        mem[16'h3000] = 16'h2205;
        run_seq(16'h3000, 0);
        run_seq(16'h3040, 0);
        check("seq.ldi_acc", 64'(done_acc), 64'd3);
`ifdef LC3_ACCESS_STATS_EN
        check("total_acc", 64'(o_total_acc), 64'd6);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_mem_access_seq.md
Name: lc3_mem_access_seq

Overview:
- Memory-access sequencer for the LC-3 core; sits between the decode/datapath and the memory bus.
- Per instruction it fetches the word at PC, decodes the opcode, and issues the operand memory cycles that opcode requires (0, 1 or 2).
- Reports the total access count per instruction. The memory-model bench uses this count to check the per-opcode access table.

Parameters:
- WAIT_TIMEOUT, 255, maximum cycles mem_req may stay high without mem_ready before abort (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin instruction sequence; accepted only when busy=0
- pc  in  16  instruction address, sampled with accepted start
- base_val  in  16  BaseR value for LDR/STR, sampled in DECODE
- src_val  in  16  store data for ST/STR/STI, sampled in DECODE
- r6_val  in  16  stack pointer for RTI, sampled in DECODE
- busy  out  1  sequence in progress
- ir  out  16  fetched instruction, held until next fetch completes
- ir_valid  out  1  one-cycle pulse in DECODE
- ld_data  out  16  data from last operand read (LD/LDR/LDI/TRAP/RTI)
- done  out  1  one-cycle pulse at normal completion
- acc_cnt  out  2  accesses made by completed instruction, valid with done
- err  out  1  one-cycle pulse on bus timeout
- mem_req  out  1  bus request
- mem_we  out  1  1=write, 0=read
- mem_addr  out  16  bus address
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, valid when mem_req&&mem_ready&&!mem_we
- mem_ready  in  1  access completes in the cycle where mem_req&&mem_ready

Behaviour:
- Reset: all outputs 0, state IDLE. The reset acts immediately and asynchronously, including mid-sequence. No done or err is produced for the aborted instruction.
- All outputs are registered. The mem_* signals stay stable while mem_req=1 and !mem_ready.
- States: IDLE, FETCH, DECODE, IND_RD, DATA_RD, DATA_WR, DONE.
- IDLE: start=1 latches pc, then FETCH. busy=1 from FETCH through DONE inclusive. start is ignored while busy.
- FETCH: read at pc. On completion, ir<=mem_rdata, then DECODE.
- DECODE (exactly 1 cycle):
  - ir_valid=1; base_val, src_val and r6_val are sampled.
  - Opcode=ir[15:12]. PCoff=pc+1+sext(ir[8:0]). Boff=base_val+sext(ir[5:0]). All address arithmetic is mod 2^16.
- Next state from DECODE, by opcode:
  - LD(2), TRAP(15), RTI(8), LDR(6): DATA_RD at PCoff, zext(ir[7:0]), r6_val, Boff respectively.
  - ST(3), STR(7): DATA_WR at PCoff or Boff respectively, wdata=src_val.
  - LDI(10), STI(11): IND_RD at PCoff.
  - All others (BR, ADD, JSR, AND, NOT, JMP, RES, LEA): DONE.
- IND_RD: read pointer ptr. Then LDI goes to DATA_RD at ptr; STI goes to DATA_WR at ptr with wdata=src_val.
- DATA_RD: ld_data<=mem_rdata on completion, then DONE. DATA_WR: on completion, DONE.
- DONE: done=1 and acc_cnt=number of completed bus accesses, then IDLE.
  - Required counts: BR/ADD/JSR/AND/NOT/JMP/RES/LEA=1; LD/ST/LDR/STR/RTI/TRAP=2; LDI/STI=3.
- Timeout: a per-access wait counter clears when each access starts. It increments each cycle with mem_req&&!mem_ready. On reaching WAIT_TIMEOUT: mem_req<=0, err pulse, go to IDLE, no done.
- Zero-wait latency (mem_ready tied 1), start at cycle 0: FETCH req cycle 1, DECODE cycle 2. done at cycle 3, 4 or 5 for 1, 2 or 3 accesses.
- The cycle after done, a new start is accepted (start may be asserted during DONE cycle but is ignored).

Optional Feature:
- Macro LC3_ACCESS_STATS_EN.
- Defined: adds output total_acc[31:0], counting every completed bus access (fetch, operand and timed-out-excluded). It wraps at 2^32 and resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- ADD word 0x1261 at pc=0x3000, mem_ready=1 -> mem_addr=0x3000 read; ir_valid cycle 2; done cycle 3, acc_cnt=1; no further mem_req.
- LD 0x2205 at pc=0x3000 -> second read at 0x3006; ld_data=mem[0x3006]; acc_cnt=2. LD with offset 0x1FF -> address 0x3000, negative sext checked.
- STI 0xB3FE at pc=0x3010, mem[0x300F]=0x4000, src_val=0xBEEF -> read 0x300F, write 0x4000 data 0xBEEF; acc_cnt=3.
- STR 0x7F81 with base_val=0xFFFF, src_val=0x1234 -> write at 0x0000 (wrap); acc_cnt=2. TRAP 0xF025 -> read 0x0025.
- mem_ready held 0 during fetch, WAIT_TIMEOUT=4 -> err pulse after 4 stalled cycles, mem_req drops, no done; next start proceeds normally. Also: 3 wait cycles -> completes normally.
- reset asserted in IND_RD -> mem_req, busy=0 immediately; start during busy ignored; total_acc (if LC3_ACCESS_STATS_EN) = 1+2+3 after ADD, LD, LDI.
